// File: rtl/cello_tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cello_tt_sweep_ctrl
//  Description : Truth-table sweep sequencer for a 4-input/1-output Cello
//                logic circuit. Walks all 16 input vectors and holds each one
//                for a settle window before sampling the circuit output. It
//                then records the measured table and checks it bit by bit
//                against the expected table.
//  Revision    : 1.0 - initial release
// ============================================================================
module cello_tt_sweep_ctrl #(
    parameter logic [15:0] TT_EXPECTED   = 16'h0239,
    parameter int          SETTLE_CYCLES = 8,
    parameter int          CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        dut_out,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [15:0] mismatch_mask,
    output logic [4:0]  fail_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Settle counter counts down to zero, so SETTLE_CYCLES-1 gives exactly
    // SETTLE_CYCLES cycles in SETTLE.
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_idx;
    logic [3:0]       r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic             w_miss;

    // Mismatch of the current sample against the expected table entry
    assign w_miss = dut_out ^ TT_EXPECTED[r_idx];

    // Output decode: drive bits map in1 = MSB of the vector index
    assign in1  = r_vec[3];
    assign in2  = r_vec[2];
    assign in3  = r_vec[1];
    assign in4  = r_vec[0];
    assign busy = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done = (r_state == S_DONE);

    // Sweep sequencer: vector drive, settle timing, capture and compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= 4'd0;
            r_vec         <= 4'd0;
            r_cnt         <= '0;
            pass          <= 1'b0;
            captured      <= 16'd0;
            mismatch_mask <= 16'd0;
            fail_count    <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // abort has priority over start
                    if (start && !abort) begin
                        r_idx         <= 4'd0;
                        r_vec         <= 4'd0;
                        r_cnt         <= CNT_RELOAD;
                        pass          <= 1'b0;
                        captured      <= 16'd0;
                        mismatch_mask <= 16'd0;
                        fail_count    <= 5'd0;
                        r_state       <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_vec   <= 4'd0;
                        pass    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    // An abort here discards this sample; partial results stay
                    if (abort) begin
                        r_vec   <= 4'd0;
                        pass    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        captured[r_idx]      <= dut_out;
                        mismatch_mask[r_idx] <= w_miss;
                        fail_count           <= fail_count + {4'd0, w_miss};
                        if (r_idx == 4'd15) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_vec   <= r_idx + 4'd1;
                            r_cnt   <= CNT_RELOAD;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    // fail_count is final here; results stay until the next start
                    pass    <= (fail_count == 5'd0);
                    r_vec   <= 4'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cello_tt_sweep_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cello_tt_sweep_ctrl
//  Description : Scoreboard bench for the truth-table sweep sequencer. The
//                circuit under test is modelled as a 16-entry lookup table.
//                Every full sweep must reproduce that table exactly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cello_tt_sweep_ctrl;

    localparam logic [15:0] TT     = 16'h0239;
    localparam int          SETTLE = 8;

    typedef struct {
        logic [15:0] cap;
        logic [15:0] mask;
        logic [4:0]  fails;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dut_out;
    logic        in1, in2, in3, in4, busy, done, pass;
    logic [15:0] captured, mismatch_mask;
    logic [4:0]  fail_count;
    logic [15:0] tbl = 16'h0000;

    logic        start1 = 1'b0;
    logic        dut_out1;
    logic        a1, a2, a3, a4, busy1, done1, pass1;
    logic [15:0] captured1, mismatch_mask1;
    logic [4:0]  fail_count1;
    logic [15:0] gold = TT;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Circuit under test: a lookup table addressed by {in1,in2,in3,in4}
    assign dut_out  = tbl[{in1, in2, in3, in4}];
    assign dut_out1 = gold[{a1, a2, a3, a4}];

    always #5 clk = ~clk;

    cello_tt_sweep_ctrl #(.TT_EXPECTED(TT), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .busy(busy), .done(done),
        .pass(pass), .captured(captured), .mismatch_mask(mismatch_mask),
        .fail_count(fail_count)
    );

    cello_tt_sweep_ctrl #(.TT_EXPECTED(TT), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .dut_out(dut_out1),
        .in1(a1), .in2(a2), .in3(a3), .in4(a4), .busy(busy1), .done(done1),
        .pass(pass1), .captured(captured1), .mismatch_mask(mismatch_mask1),
        .fail_count(fail_count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: vector order and timing while busy, scoreboard pop on done
    int   busy_cnt = 0;
    int   vec_bad  = 0;
    bit   chk_pass = 1'b0;
    logic exp_pass = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_pass) begin
            chk("pass_after_done", {31'd0, pass}, {31'd0, exp_pass});
            chk_pass = 1'b0;
        end
        if (busy) begin
            if ({in1, in2, in3, in4} != 4'(busy_cnt / (SETTLE + 1))) vec_bad++;
            busy_cnt++;
        end else if (done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = sb_q.pop_front();
                chk("captured", {16'd0, captured}, {16'd0, e.cap});
                chk("mismatch_mask", {16'd0, mismatch_mask}, {16'd0, e.mask});
                chk("fail_count", {27'd0, fail_count}, {27'd0, e.fails});
                chk("busy_cycles", busy_cnt, 16 * (SETTLE + 1));
                chk("vector_sequence_errs", vec_bad, 0);
                exp_pass = e.pass;
                chk_pass = 1'b1;
            end
            busy_cnt = 0;
            vec_bad  = 0;
        end else begin
            if ({in1, in2, in3, in4} != 4'd0) vec_bad++;
            busy_cnt = 0;
        end
    end

    task automatic push_exp(input logic [15:0] t);
        exp_t e;
        e.cap   = t;
        e.mask  = t ^ TT;
        e.fails = 5'($countones(t ^ TT));
        e.pass  = ((t ^ TT) == 16'd0);
        sb_q.push_back(e);
    endtask

    // Full sweep; optionally pulse start randomly while busy
    task automatic do_sweep(input logic [15:0] t, input bit noisy);
        tbl = t;
        push_exp(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) break;
            if (noisy) start = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL sweep_timeout actual=0 expected=1");
            sb_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Start a sweep and stop at busy cycle k with abort
    task automatic abort_at(input logic [15:0] t, input int k);
        tbl = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (k) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_vec", {28'd0, in1, in2, in3, in4}, 32'd0);
        chk("rst_captured", {16'd0, captured}, 32'd0);
        chk("rst_fail_count", {27'd0, fail_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Golden circuit with start hammered during the sweep
        do_sweep(TT, 1'b1);
        repeat (10) @(negedge clk);

        // Reset mid-sweep, at busy cycle 49
        tbl = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_pass", {31'd0, pass}, 32'd0);
        chk("midrst_captured", {16'd0, captured}, 32'd0);
        chk("midrst_mask", {16'd0, mismatch_mask}, 32'd0);
        chk("midrst_fail_count", {27'd0, fail_count}, 32'd0);
        chk("midrst_vec", {28'd0, in1, in2, in3, in4}, 32'd0);
        @(negedge clk);

        do_sweep(16'h0000, 1'b0);
        do_sweep(16'hFFFF, 1'b0);
        for (int i = 0; i < 4; i++) do_sweep(16'($urandom), 1'b1);
        do_sweep(TT, 1'b0);

        // Abort during vector 5 settle (busy cycle 47) with output tied 1
        abort_at(16'hFFFF, 47);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_pass", {31'd0, pass}, 32'd0);
        chk("abort_captured", {16'd0, captured}, 32'h001F);
        chk("abort_mask", {16'd0, mismatch_mask}, 32'h0006);
        chk("abort_fail_count", {27'd0, fail_count}, 32'd2);
        chk("abort_vec", {28'd0, in1, in2, in3, in4}, 32'd0);
        repeat (20) @(negedge clk);

        // start together with abort in IDLE must not start a sweep
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", {31'd0, busy}, 32'd0);
        chk("start_abort_captured", {16'd0, captured}, 32'h001F);

        // Abort in the first SAMPLE cycle suppresses that sample
        abort_at(16'hFFFF, SETTLE);
        chk("abort_sample_captured", {16'd0, captured}, 32'd0);
        chk("abort_sample_fail_count", {27'd0, fail_count}, 32'd0);
        repeat (5) @(negedge clk);

        // A clean sweep after aborts
        do_sweep(TT, 1'b0);

        // SETTLE_CYCLES=1 instance: 32 busy cycles
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (done1) break;
            if (busy1) n++;
            @(negedge clk);
        end
        chk("s1_done_seen", {31'd0, done1}, 32'd1);
        chk("s1_busy_cycles", n, 32);
        chk("s1_captured", {16'd0, captured1}, {16'd0, TT});
        chk("s1_fail_count", {27'd0, fail_count1}, 32'd0);
        @(negedge clk);
        chk("s1_pass", {31'd0, pass1}, 32'd1);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
